// File: rtl/sel_pkg.sv
// Shared constants and helpers for the one-hot select sequencer.
package sel_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned MAX_SEL = 8;
  localparam int unsigned MAX_OUT = 1 << MAX_SEL;

  // One-hot vector with bit idx set; zero if idx falls outside width.
  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL-1:0] idx,
                                                input int unsigned width);
    logic [MAX_OUT-1:0] v;
    v = '0;
    if (32'(idx) < width) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational N-to-2^N one-hot decoder with enable.
module onehot_dec
  import sel_pkg::*;
#(
  parameter int unsigned SEL_WIDTH = 2
) (
  input  logic [SEL_WIDTH-1:0]      idx,
  input  logic                      en,
  output logic [(1<<SEL_WIDTH)-1:0] out_c
);

  localparam int unsigned OUT_COUNT = 1 << SEL_WIDTH;

  always_comb begin
    out_c = '0;
    if (en) out_c = OUT_COUNT'(onehot(MAX_SEL'(idx), OUT_COUNT));
  end

endmodule

// File: rtl/onehot_sel_seq.sv
// Registered one-hot select: load/step (wrapping) index, held or strobed output,
// with a same-cycle output mask that leaves state untouched.
module onehot_sel_seq
  import sel_pkg::*;
#(
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned UUID      = 0,
  parameter string       NAME      = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_WIDTH-1:0]      sel,
  input  logic                      load,
  input  logic                      step,
  input  logic                      dir,
  input  logic                      pulse_mode,
  input  logic                      dis,
  output logic [(1<<SEL_WIDTH)-1:0] out,
  output logic [SEL_WIDTH-1:0]      index,
  output logic                      valid,
  output logic                      wrap
);

  if (SEL_WIDTH < 1 || SEL_WIDTH > MAX_SEL) begin : g_bad_width
    $error("onehot_sel_seq %s (uuid %0d): SEL_WIDTH out of range", NAME, UUID);
  end

  logic [SEL_WIDTH-1:0] cur_q, cur_d;
  logic                 active_q, active_d;
  logic                 wrap_q, wrap_d;

  // Next state: load beats step beats idle; an inactive step only re-arms.
  always_comb begin
    cur_d    = cur_q;
    active_d = active_q;
    wrap_d   = 1'b0;
    if (load) begin
      cur_d    = sel;
      active_d = 1'b1;
    end else if (step) begin
      active_d = 1'b1;
      if (active_q) begin
        if (dir == DIR_UP) begin
          cur_d  = cur_q + SEL_WIDTH'(1);
          wrap_d = &cur_q;
        end else begin
          cur_d  = cur_q - SEL_WIDTH'(1);
          wrap_d = ~|cur_q;
        end
      end
    end else if (pulse_mode) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q    <= '0;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
    end
  end

  // Mask is applied after the registers so it never disturbs sequencing.
  assign valid = active_q & ~dis;
  assign index = cur_q;
  assign wrap  = wrap_q;

  onehot_dec #(.SEL_WIDTH(SEL_WIDTH)) u_dec (
    .idx   (cur_q),
    .en    (valid),
    .out_c (out)
  );

endmodule

// File: tb/tb_onehot_sel_seq.sv
// Directed, table-driven bench for onehot_sel_seq (2-bit and 3-bit instances).
module tb_onehot_sel_seq;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-bit instance signals
  logic       rst, load, step, dir, pm, dis;
  logic [1:0] sel;
  logic [3:0] out;
  logic [1:0] index;
  logic       valid, wrap;

  // 3-bit instance signals
  logic       rst3, load3, step3, dir3, pm3, dis3;
  logic [2:0] sel3;
  logic [7:0] out3;
  logic [2:0] index3;
  logic       valid3, wrap3;

  onehot_sel_seq #(.SEL_WIDTH(2), .UUID(1), .NAME("w2")) dut (
    .clk(clk), .rst(rst), .sel(sel), .load(load), .step(step), .dir(dir),
    .pulse_mode(pm), .dis(dis), .out(out), .index(index), .valid(valid), .wrap(wrap)
  );

  onehot_sel_seq #(.SEL_WIDTH(3), .UUID(2), .NAME("w3")) dut3 (
    .clk(clk), .rst(rst3), .sel(sel3), .load(load3), .step(step3), .dir(dir3),
    .pulse_mode(pm3), .dis(dis3), .out(out3), .index(index3), .valid(valid3), .wrap(wrap3)
  );

  typedef struct {
    logic       rst, load;
    logic [1:0] sel;
    logic       step, dir, pm, dis;
    logic [3:0] e_out;
    logic [1:0] e_idx;
    logic       e_valid, e_wrap;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic add(input logic r, input logic ld, input logic [1:0] s, input logic st,
                     input logic d, input logic p, input logic ds, input logic [3:0] eo,
                     input logic [1:0] ei, input logic ev, input logic ew);
    vec_t v;
    v.rst = r; v.load = ld; v.sel = s; v.step = st; v.dir = d; v.pm = p; v.dis = ds;
    v.e_out = eo; v.e_idx = ei; v.e_valid = ev; v.e_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic drive2(input logic r, input logic ld, input logic [1:0] s, input logic st,
                        input logic d, input logic p, input logic ds);
    rst = r; load = ld; sel = s; step = st; dir = d; pm = p; dis = ds;
  endtask

  task automatic drive3(input logic r, input logic ld, input logic [2:0] s, input logic st,
                        input logic d);
    rst3 = r; load3 = ld; sel3 = s; step3 = st; dir3 = d; pm3 = L; dis3 = L;
  endtask

  initial begin
    drive2(H, L, 2'd0, L, L, L, L);
    drive3(H, L, 3'd0, L, L);

    //  rst load sel  step dir pm dis | out      idx  valid wrap
    add(H, H, 2'd3, L, L, L, L, 4'b0000, 2'd0, L, L);  // reset beats load
    add(H, H, 2'd3, L, L, L, L, 4'b0000, 2'd0, L, L);
    add(L, H, 2'd2, L, L, L, L, 4'b0100, 2'd2, H, L);  // load 2
    for (int i = 0; i < 5; i++)
      add(L, L, 2'd0, L, L, L, L, 4'b0100, 2'd2, H, L);  // held
    add(L, H, 2'd3, L, L, L, L, 4'b1000, 2'd3, H, L);
    add(L, L, 2'd0, H, L, L, L, 4'b0001, 2'd0, H, H);  // up 3->0 wraps
    add(L, L, 2'd0, H, H, L, L, 4'b1000, 2'd3, H, H);  // down 0->3 wraps
    add(L, H, 2'd1, L, L, L, L, 4'b0010, 2'd1, H, L);
    add(L, L, 2'd0, H, L, L, L, 4'b0100, 2'd2, H, L);  // 1->2, no wrap
    add(L, H, 2'd1, H, L, L, L, 4'b0010, 2'd1, H, L);  // load wins over step
    add(L, H, 2'd3, L, L, L, L, 4'b1000, 2'd3, H, L);
    add(L, L, 2'd0, L, L, L, H, 4'b0000, 2'd3, L, L);  // masked
    add(L, L, 2'd0, H, L, L, H, 4'b0000, 2'd0, L, H);  // step while masked
    add(L, L, 2'd0, L, L, L, L, 4'b0001, 2'd0, H, L);  // unmasked
    add(L, H, 2'd1, L, L, H, L, 4'b0010, 2'd1, H, L);  // pulse load
    add(L, L, 2'd0, L, L, H, L, 4'b0000, 2'd1, L, L);  // strobe drops
    add(L, L, 2'd0, H, L, H, L, 4'b0010, 2'd1, H, L);  // inactive step arms only
    add(L, L, 2'd0, H, L, H, L, 4'b0100, 2'd2, H, L);  // back-to-back keeps valid
    add(L, L, 2'd0, H, H, H, L, 4'b0010, 2'd1, H, L);
    add(L, L, 2'd0, L, L, H, L, 4'b0000, 2'd1, L, L);
    add(L, L, 2'd0, H, L, L, L, 4'b0010, 2'd1, H, L);  // re-arm, then hold
    add(L, L, 2'd0, H, L, L, L, 4'b0100, 2'd2, H, L);
    add(H, L, 2'd0, H, L, L, L, 4'b0000, 2'd0, L, L);  // reset mid-sequence
    add(L, L, 2'd0, L, L, L, L, 4'b0000, 2'd0, L, L);

    foreach (vecs[i]) begin
      drive2(vecs[i].rst, vecs[i].load, vecs[i].sel, vecs[i].step, vecs[i].dir,
             vecs[i].pm, vecs[i].dis);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out", i),   8'(out),   8'(vecs[i].e_out));
      chk($sformatf("v%0d_idx", i),   8'(index), 8'(vecs[i].e_idx));
      chk($sformatf("v%0d_valid", i), 8'(valid), 8'(vecs[i].e_valid));
      chk($sformatf("v%0d_wrap", i),  8'(wrap),  8'(vecs[i].e_wrap));
    end

    // Mask takes effect and releases without a clock edge.
    drive2(L, H, 2'd3, L, L, L, L);
    @(posedge clk); #1;
    drive2(L, L, 2'd0, L, L, L, L);
    chk("pre_mask_out", 8'(out), 8'h08);
    dis = H; #1;
    chk("mask_same_cycle_out", 8'(out), 8'h00);
    chk("mask_same_cycle_valid", 8'(valid), 8'h00);
    dis = L; #1;
    chk("unmask_same_cycle_out", 8'(out), 8'h08);
    chk("unmask_same_cycle_valid", 8'(valid), 8'h01);

    // 3-bit instance: eight up-steps from 0, wrap only on 7->0.
    @(posedge clk); #1;
    chk("w3_reset_out", 8'(out3), 8'h00);
    drive3(L, H, 3'd0, L, L);
    @(posedge clk); #1;
    chk("w3_load_out", out3, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      logic [2:0] ei;
      logic [7:0] eo;
      ei = 3'(i % 8);
      eo = 8'h01 << ei;
      drive3(L, L, 3'd0, H, L);
      @(posedge clk); #1;
      chk($sformatf("w3_step%0d_idx", i),  8'(index3), 8'(ei));
      chk($sformatf("w3_step%0d_out", i),  out3,       eo);
      chk($sformatf("w3_step%0d_wrap", i), 8'(wrap3),  (i == 8) ? 8'h01 : 8'h00);
    end
    drive3(L, L, 3'd0, L, L);
    @(posedge clk); #1;
    chk("w3_wrap_clears", 8'(wrap3), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
